// File: rtl/vga_tile_scanner_pkg.sv
// vga_pkg: 640x480@60 Hz timing constants and tile geometry shared by the
// display scanner and its timing generator. No ports.
package vga_pkg;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = 800;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = 525;

  localparam int unsigned TILE_W    = 20;
  localparam int unsigned TILE_H    = 15;
  localparam int unsigned TILES     = 32;

  // Sync windows as half-open ranges [START, END).
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
endpackage

// File: rtl/vga_tile_scanner_if.sv
// vga_tile_scanner_if: RAM display read port.
//   dispAddr  - tile word address (scanner -> RAM)
//   dispColor - word at dispAddr, combinational from the RAM (RAM -> scanner)
// master = scanner side, slave = RAM side.
interface vga_tile_scanner_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] dispAddr;
  logic [DATA_WIDTH-1:0] dispColor;

  modport master (output dispAddr, input dispColor);
  modport slave  (input dispAddr, output dispColor);
endinterface

// File: rtl/vga_tile_scanner_timing.sv
// vga_timing: pixel-clock enable and raw VGA beam counters.
//   clk, rst      - system clock, synchronous active-low reset
//   pix_ce        - one-clock pixel tick every CLK_DIV clocks
//   h, v          - beam position (0..799, 0..524)
//   h_wrap/v_wrap - qualified with pix_ce: this tick ends the line / frame
module vga_timing #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_ce,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       h_wrap,
  output logic       v_wrap
);
  import vga_pkg::*;

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // With CLK_DIV=1 div is stuck at 0 == DIV_LAST, so pix_ce is constant 1.
  assign pix_ce = (div == DIV_LAST);
  assign h_wrap = pix_ce && (h == 10'(H_TOTAL - 1));
  assign v_wrap = h_wrap && (v == 10'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= pix_ce ? '0 : div + 1'b1;
      if (pix_ce) h <= h_wrap ? '0 : h + 1'b1;
      if (h_wrap) v <= v_wrap ? '0 : v + 1'b1;
    end
  end
endmodule

// File: rtl/vga_tile_scanner.sv
// vga_tile_scanner: scans the RAM's 1024-word window as a 32x32 grid of
// RGB444 tiles and drives 640x480@60 Hz VGA.
//   clk, rst     - system clock, synchronous active-low reset
//   en           - display enable (0 blanks RGB, timing keeps running)
//   disp         - RAM display read port (dispAddr out, dispColor in)
//   vga_r/g/b    - registered pixel colour
//   hsync, vsync - registered active-low sync
//   frame_start  - one-clock pulse when h=0,v=0 reaches the outputs
module vga_tile_scanner #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  vga_tile_scanner_if.master   disp,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start
);
  import vga_pkg::*;

  logic       pix_ce, h_wrap, v_wrap;
  logic [9:0] h, v;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (pix_ce),
    .h      (h),
    .v      (v),
    .h_wrap (h_wrap),
    .v_wrap (v_wrap)
  );

  logic [4:0] sub_x, tile_x, tile_y;
  logic [3:0] sub_y;
  logic [4:0] sub_x_n, tile_x_n, tile_y_n;
  logic [3:0] sub_y_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic       active;
  logic       unused_color_bits;

  // Tile counters step on the same tick as h/v, and dispAddr is loaded from
  // their next values, so the address always matches the current (h, v) and
  // the RAM word is ready when the output stage samples it one tick later.
  // Advancing stops on the last visible pixel/line so the address holds.
  always_comb begin
    sub_x_n  = sub_x;
    tile_x_n = tile_x;
    sub_y_n  = sub_y;
    tile_y_n = tile_y;
    if (h_wrap) begin
      sub_x_n  = '0;
      tile_x_n = '0;
      if (v_wrap) begin
        sub_y_n  = '0;
        tile_y_n = '0;
      end else if (v < 10'(V_VISIBLE - 1)) begin
        if (sub_y == 4'(TILE_H - 1)) begin
          sub_y_n  = '0;
          tile_y_n = tile_y + 1'b1;
        end else begin
          sub_y_n = sub_y + 1'b1;
        end
      end
    end else if (pix_ce && (h < 10'(H_VISIBLE - 1))) begin
      if (sub_x == 5'(TILE_W - 1)) begin
        sub_x_n  = '0;
        tile_x_n = tile_x + 1'b1;
      end else begin
        sub_x_n = sub_x + 1'b1;
      end
    end
  end

  assign addr_n            = ADDR_WIDTH'({tile_y_n, tile_x_n});
  assign active            = (h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE));
  assign unused_color_bits = ^disp.dispColor[DATA_WIDTH-1:12];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sub_x         <= '0;
      tile_x        <= '0;
      sub_y         <= '0;
      tile_y        <= '0;
      disp.dispAddr <= '0;
    end else begin
      sub_x         <= sub_x_n;
      tile_x        <= tile_x_n;
      sub_y         <= sub_y_n;
      tile_y        <= tile_y_n;
      disp.dispAddr <= addr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      {vga_r, vga_g, vga_b} <= '0;
      hsync                 <= 1'b1;
      vsync                 <= 1'b1;
      frame_start           <= 1'b0;
    end else begin
      frame_start <= pix_ce && (h == '0) && (v == '0);
      if (pix_ce) begin
        {vga_r, vga_g, vga_b} <= (active && en) ? disp.dispColor[11:0] : '0;
        hsync <= !((h >= 10'(H_SYNC_START)) && (h < 10'(H_SYNC_END)));
        vsync <= !((v >= 10'(V_SYNC_START)) && (v < 10'(V_SYNC_END)));
      end
    end
  end
endmodule

// File: tb/tb_vga_tile_scanner.sv
module tb_vga_tile_scanner;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] mem [1024];

  vga_tile_scanner_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus4 ();
  vga_tile_scanner_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus1 ();
  assign bus4.dispColor = mem[bus4.dispAddr];
  assign bus1.dispColor = mem[bus1.dispAddr];

  logic [3:0] r4, g4, b4, r1, g1, b1;
  logic hs4, vs4, fs4, hs1, vs1, fs1;

  vga_tile_scanner #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CLK_DIV(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .disp(bus4),
    .vga_r(r4), .vga_g(g4), .vga_b(b4),
    .hsync(hs4), .vsync(vs4), .frame_start(fs4)
  );
  vga_tile_scanner #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .disp(bus1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  // index 0 = CLK_DIV 4 instance, index 1 = CLK_DIV 1 instance
  logic [11:0] a_rgb [2];
  logic        a_hs [2], a_vs [2], a_fs [2];
  logic [9:0]  a_addr [2];
  assign a_rgb[0] = {r4, g4, b4};
  assign a_rgb[1] = {r1, g1, b1};
  assign a_hs[0] = hs4;  assign a_hs[1] = hs1;
  assign a_vs[0] = vs4;  assign a_vs[1] = vs1;
  assign a_fs[0] = fs4;  assign a_fs[1] = fs1;
  assign a_addr[0] = bus4.dispAddr;
  assign a_addr[1] = bus1.dispAddr;

  int tests = 0;
  int fails = 0;

  // Reference model: n = clock edges since reset release. Pixel tick m
  // happens on edge m*div; after it the pins show beam position m-1 and the
  // beam (and address) sits on position m. Positions come from plain
  // division of the tick count by line/frame lengths.
  int          n = 0;
  logic [11:0] e_rgb [2];
  logic        e_hs [2], e_vs [2], e_fs [2], e_aok [2];
  logic [9:0]  e_addr [2];
  int          o_h [2], o_v [2];

  always @(posedge clk) begin : model
    int nn, d, p, hh, vv, q, qh, qv;
    if (!rst) begin
      n <= 0;
      for (int k = 0; k < 2; k++) begin
        e_rgb[k] <= '0; e_hs[k] <= 1'b1; e_vs[k] <= 1'b1; e_fs[k] <= 1'b0;
        e_aok[k] <= 1'b1; e_addr[k] <= '0; o_h[k] <= -1; o_v[k] <= -1;
      end
    end else begin
      nn = n + 1;
      n <= nn;
      for (int k = 0; k < 2; k++) begin
        d = (k == 0) ? 4 : 1;
        e_fs[k] <= 1'b0;
        if (nn % d == 0) begin
          p  = nn / d - 1;
          hh = p % 800;
          vv = (p / 800) % 525;
          if (hh < 640 && vv < 480 && en) e_rgb[k] <= mem[(vv / 15) * 32 + hh / 20][11:0];
          else                           e_rgb[k] <= '0;
          e_hs[k] <= !(hh >= 656 && hh < 752);
          e_vs[k] <= !(vv >= 490 && vv < 492);
          e_fs[k] <= (hh == 0 && vv == 0);
          q  = p + 1;
          qh = q % 800;
          qv = (q / 800) % 525;
          e_aok[k]  <= (qh < 640 && qv < 480);
          e_addr[k] <= 10'((qv / 15) * 32 + qh / 20);
          o_h[k] <= hh;
          o_v[k] <= vv;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int first [2], pulses [2];
    rst = 1'b0;
    en  = 1'b1;
    repeat (5) begin
      step();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({a_rgb[k], a_hs[k], a_vs[k], a_fs[k], a_addr[k]} !== {12'h000, 1'b1, 1'b1, 1'b0, 10'd0}) begin
          fails++;
          $display("FAIL reset_state dut%0d got rgb=%h hs=%b vs=%b fs=%b addr=%0d want rgb=000 hs=1 vs=1 fs=0 addr=0",
                   k, a_rgb[k], a_hs[k], a_vs[k], a_fs[k], a_addr[k]);
        end
      end
    end
    rst = 1'b1;
    first[0] = 0; first[1] = 0; pulses[0] = 0; pulses[1] = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      for (int k = 0; k < 2; k++)
        if (a_fs[k] === 1'b1) begin
          pulses[k]++;
          if (first[k] == 0) first[k] = c;
        end
    end
    tests++;
    if (first[0] != 4) begin fails++; $display("FAIL fs_latency_div4 got=%0d want=4", first[0]); end
    tests++;
    if (first[1] != 1) begin fails++; $display("FAIL fs_latency_div1 got=%0d want=1", first[1]); end
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (pulses[k] != 1) begin fails++; $display("FAIL fs_pulse_count dut%0d got=%0d want=1", k, pulses[k]); end
    end
  endtask

  // Line 0 of the CLK_DIV=1 instance: address steps by one every 20 ticks.
  task automatic test_addr_walk();
    logic [9:0] prev;
    int last, steps;
    prev = a_addr[1];
    last = 0;
    steps = 0;
    for (int c = 0; c < 632; c++) begin
      step();
      if (a_addr[1] !== prev) begin
        steps++;
        tests++;
        if (a_addr[1] !== prev + 10'd1 || n - last != 20) begin
          fails++;
          $display("FAIL addr_step n=%0d got addr=%0d gap=%0d want addr=%0d gap=20", n, a_addr[1], n - last, prev + 10'd1);
        end
        prev = a_addr[1];
        last = n;
      end
    end
    tests++;
    if (steps != 31 || a_addr[1] !== 10'd31) begin
      fails++;
      $display("FAIL addr_walk_end got steps=%0d addr=%0d want steps=31 addr=31", steps, a_addr[1]);
    end
    tests++;
    if (a_addr[0] !== 10'd8) begin fails++; $display("FAIL addr_div4_at_h160 got=%0d want=8", a_addr[0]); end
  endtask

  task automatic test_scan(input int cycles, input bit writes);
    for (int c = 0; c < cycles; c++) begin
      if (writes && ($urandom_range(0, 15) == 0)) mem[$urandom_range(0, 1023)] = $urandom;
      step();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({a_rgb[k], a_hs[k], a_vs[k], a_fs[k]} !== {e_rgb[k], e_hs[k], e_vs[k], e_fs[k]}) begin
          fails++;
          $display("FAIL scan_out dut%0d n=%0d got rgb=%h hs=%b vs=%b fs=%b want rgb=%h hs=%b vs=%b fs=%b",
                   k, n, a_rgb[k], a_hs[k], a_vs[k], a_fs[k], e_rgb[k], e_hs[k], e_vs[k], e_fs[k]);
        end
        if (e_aok[k]) begin
          tests++;
          if (a_addr[k] !== e_addr[k]) begin
            fails++;
            $display("FAIL scan_addr dut%0d n=%0d got=%0d want=%0d", k, n, a_addr[k], e_addr[k]);
          end
        end
      end
    end
  endtask

  // 3200 clocks = one CLK_DIV=4 line = four CLK_DIV=1 lines: 384 low clocks each.
  task automatic test_hsync();
    int lows [2], vlows [2];
    lows[0] = 0; lows[1] = 0; vlows[0] = 0; vlows[1] = 0;
    for (int c = 0; c < 3200; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (a_hs[k] === 1'b0) lows[k]++;
        if (a_vs[k] === 1'b0) vlows[k]++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (lows[k] != 384) begin fails++; $display("FAIL hsync_low_clocks dut%0d got=%0d want=384", k, lows[k]); end
      tests++;
      if (vlows[k] != 0) begin fails++; $display("FAIL vsync_low_in_visible dut%0d got=%0d want=0", k, vlows[k]); end
    end
  endtask

  // Tile 33 holds 0xABC with junk in the upper bits; watch lines 15..29.
  task automatic test_colour();
    int hits, cycles;
    mem[33] = 32'hFFFF_FABC;
    hits = 0;
    cycles = 24002 - n;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (n == 12000) begin
        tests++;
        if (a_addr[1] !== 10'd32) begin fails++; $display("FAIL addr_row15_first got=%0d want=32", a_addr[1]); end
      end
      if (o_v[1] >= 15 && o_v[1] <= 29 && o_h[1] >= 20 && o_h[1] <= 39) begin
        hits++;
        tests++;
        if (a_rgb[1] !== 12'hABC) begin
          fails++;
          $display("FAIL colour_tile33 h=%0d v=%0d got=%h want=abc", o_h[1], o_v[1], a_rgb[1]);
        end
      end else if (o_h[1] >= 640) begin
        tests++;
        if (a_rgb[1] !== 12'h000) begin
          fails++;
          $display("FAIL colour_porch h=%0d v=%0d got=%h want=000", o_h[1], o_v[1], a_rgb[1]);
        end
      end
    end
    tests++;
    if (hits != 300) begin fails++; $display("FAIL colour_tile33_pixels got=%0d want=300", hits); end
  endtask

  task automatic test_enable();
    bit ticked [2];
    en = 1'b0;
    ticked[0] = 0; ticked[1] = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (n % ((k == 0) ? 4 : 1) == 0) ticked[k] = 1;
        if (ticked[k]) begin
          tests++;
          if (a_rgb[k] !== 12'h000) begin fails++; $display("FAIL en_off_rgb dut%0d n=%0d got=%h want=000", k, n, a_rgb[k]); end
        end
        tests++;
        if (a_hs[k] !== e_hs[k] || a_vs[k] !== e_vs[k]) begin
          fails++;
          $display("FAIL en_off_sync dut%0d got hs=%b vs=%b want hs=%b vs=%b", k, a_hs[k], a_vs[k], e_hs[k], e_vs[k]);
        end
      end
    end
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (a_rgb[k] !== e_rgb[k]) begin fails++; $display("FAIL en_resume dut%0d n=%0d got=%h want=%h", k, n, a_rgb[k], e_rgb[k]); end
      end
    end
  endtask

  // One-clock reset while the CLK_DIV=1 beam is at v=31, h=400.
  task automatic test_midframe_reset();
    int first [2], pulses [2], cycles;
    cycles = 25200 - n;
    for (int c = 0; c < cycles; c++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({a_rgb[k], a_hs[k], a_vs[k], a_fs[k], a_addr[k]} !== {12'h000, 1'b1, 1'b1, 1'b0, 10'd0}) begin
        fails++;
        $display("FAIL midreset_state dut%0d got rgb=%h hs=%b vs=%b fs=%b addr=%0d want rgb=000 hs=1 vs=1 fs=0 addr=0",
                 k, a_rgb[k], a_hs[k], a_vs[k], a_fs[k], a_addr[k]);
      end
    end
    first[0] = 0; first[1] = 0; pulses[0] = 0; pulses[1] = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      for (int k = 0; k < 2; k++)
        if (a_fs[k] === 1'b1) begin
          pulses[k]++;
          if (first[k] == 0) first[k] = c;
        end
    end
    tests++;
    if (first[0] != 4 || first[1] != 1) begin
      fails++;
      $display("FAIL midreset_fs_latency got div4=%0d div1=%0d want div4=4 div1=1", first[0], first[1]);
    end
    tests++;
    if (pulses[0] != 1 || pulses[1] != 1) begin
      fails++;
      $display("FAIL midreset_fs_pulses got div4=%0d div1=%0d want 1 and 1", pulses[0], pulses[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset();
    test_addr_walk();
    test_scan(3300, 1'b1);
    test_hsync();
    test_colour();
    test_enable();
    test_midframe_reset();
    test_scan(1000, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
